// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: segment bit positions and the active-low hex glyph table.
package seven_seg_pkg;
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    typedef logic [6:0] glyph_t;

    // bit 0 = a ... bit 6 = g, 0 = segment on; b and d are lowercase
    localparam glyph_t HEX_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
endpackage

// File: rtl/seven_seg_scanner_hex_to_7seg.sv
// hex_to_7seg: combinational nibble to active-low a..g glyph.
module hex_to_7seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output glyph_t     seg
);
    assign seg = HEX_GLYPH[nibble];
endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: multiplexed N-digit seven-segment driver with tear-free
// double-buffered load, per-digit dp/blank/blink and global PWM brightness.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_HZ     = 100_000_000,
    parameter int REFRESH_HZ = 1000,
    parameter int PWM_BITS   = 4,
    parameter int BLINK_HZ   = 2
) (
    input  logic                    CLK100MHZ,
    input  logic                    BTNC,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic [NUM_DIGITS-1:0]   blink,
    input  logic                    load,
    input  logic [PWM_BITS-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic [7:0]              SD,
    output logic                    frame_tick
);
    localparam int DIV  = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
    localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int SW   = $clog2(DIV);
    localparam int BW   = HALF > 1 ? $clog2(HALF) : 1;
    localparam int IW   = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;

    typedef struct packed {
        logic [NUM_DIGITS-1:0]      blink;
        logic [NUM_DIGITS-1:0]      blank;
        logic [NUM_DIGITS-1:0]      dp;
        logic [NUM_DIGITS-1:0][3:0] data;
    } frame_t;

    frame_t          live;
    frame_t          stage;
    frame_t          active;
    logic [SW-1:0]   slot_cnt;
    logic [IW-1:0]   idx;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [BW-1:0]   blink_cnt;
    logic            blink_phase;
    logic            slot_last;
    logic            blink_last;
    logic            pwm_on;
    logic            lit;
    glyph_t          glyph;
    logic [7:0]      sd_lit;

    assign live       = {blink, blank, dp, data};
    assign slot_last  = slot_cnt == SW'(DIV - 1);
    assign blink_last = blink_cnt == BW'(HALF - 1);
    assign frame_tick = slot_last && idx == IW'(NUM_DIGITS - 1);
    assign pwm_on     = &brightness || pwm_cnt < brightness;
    assign lit        = pwm_on && !active.blank[idx] && !(active.blink[idx] && blink_phase);

    hex_to_7seg u_dec (
        .nibble (active.data[idx]),
        .seg    (glyph)
    );

    always_comb begin
        sd_lit              = SEG_OFF;
        sd_lit[SEG_G:SEG_A] = glyph;
        sd_lit[SEG_DP]      = !active.dp[idx];
    end

    always_ff @(posedge CLK100MHZ or posedge BTNC) begin
        if (BTNC) begin
            slot_cnt    <= '0;
            idx         <= '0;
            pwm_cnt     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            stage       <= '0;
            active      <= '0;
            AN          <= '1;
            SD          <= SEG_OFF;
        end else begin
            slot_cnt  <= slot_last ? '0 : slot_cnt + 1'b1;
            pwm_cnt   <= pwm_cnt + 1'b1;
            blink_cnt <= blink_last ? '0 : blink_cnt + 1'b1;
            if (slot_last)
                idx <= frame_tick ? '0 : idx + 1'b1;
            if (blink_last)
                blink_phase <= !blink_phase;
            if (load)
                stage <= live;
            // a load landing on the frame boundary bypasses staging so it is not lost
            if (frame_tick)
                active <= load ? live : stage;
            // slot_last precomputes the dark anti-ghost cycle that opens the next slot
            AN <= lit && !slot_last ? ~(NUM_DIGITS'(1) << idx) : '1;
            SD <= lit ? sd_lit : SEG_OFF;
        end
    end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: queued per-cycle expectations checked by a negedge monitor plus direct async-reset checks.
module tb_seven_seg_scanner;
    logic        CLK100MHZ = 1'b0;
    logic        BTNC;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  blink;
    logic        load;
    logic [1:0]  brightness;
    logic [3:0]  AN;
    logic [7:0]  SD;
    logic        frame_tick;

    typedef struct {
        int         t;
        logic [3:0] an;
        logic [7:0] sd;
        logic       ft;
        bit         use_an;
        bit         use_sd;
        bit         use_ft;
        string      name;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    logic [6:0] glyph_tbl [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    seven_seg_scanner #(
        .NUM_DIGITS (4),
        .CLK_HZ     (1600),
        .REFRESH_HZ (25),
        .PWM_BITS   (2),
        .BLINK_HZ   (25)
    ) dut (
        .CLK100MHZ  (CLK100MHZ),
        .BTNC       (BTNC),
        .data       (data),
        .dp         (dp),
        .blank      (blank),
        .blink      (blink),
        .load       (load),
        .brightness (brightness),
        .AN         (AN),
        .SD         (SD),
        .frame_tick (frame_tick)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    always @(posedge CLK100MHZ or posedge BTNC)
        cyc <= BTNC ? 0 : cyc + 1;

    always @(negedge CLK100MHZ) begin
        while (q.size() != 0 && q[0].t <= cyc) begin
            cur = q.pop_front();
            n_vec++;
            if (cur.t != cyc || (cur.use_an && AN !== cur.an) || (cur.use_sd && SD !== cur.sd)
                || (cur.use_ft && frame_tick !== cur.ft)) begin
                n_err++;
                $display("FAIL %s at t=%0d (due t=%0d): got AN=%b SD=%h frame_tick=%b, want AN=%b SD=%h frame_tick=%b",
                         cur.name, cyc, cur.t, AN, SD, frame_tick, cur.an, cur.sd, cur.ft);
            end
        end
    end

    task automatic add(input int t, input logic [3:0] an, input logic [7:0] sd, input logic ft,
                       input bit ua, input bit us, input bit uf, input string name);
        exp_t e;
        e.t = t; e.an = an; e.sd = sd; e.ft = ft;
        e.use_an = ua; e.use_sd = us; e.use_ft = uf; e.name = name;
        q.push_back(e);
    endtask

    task automatic px(input int t, input logic [3:0] an, input logic [7:0] sd, input string name);
        add(t, an, sd, 1'b0, 1'b1, 1'b1, 1'b0, name);
    endtask

    task automatic dark(input int t, input string name);
        add(t, 4'hF, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, name);
    endtask

    task automatic ghost(input int t, input string name);
        add(t, 4'hF, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, name);
    endtask

    task automatic tick(input int t, input logic v, input string name);
        add(t, 4'hF, 8'hFF, v, 1'b0, 1'b0, 1'b1, name);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge CLK100MHZ);
    endtask

    task automatic do_load(input int n, input logic [15:0] d, input logic [3:0] p,
                           input logic [3:0] bl, input logic [3:0] bk);
        wait_cyc(n);
        data = d; dp = p; blank = bl; blink = bk; load = 1'b1;
        wait_cyc(n + 1);
        load = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t left;
        BTNC = 1'b1; data = '0; dp = '0; blank = '0; blink = '0; load = 1'b0; brightness = 2'd3;
        add(0, 4'hF, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, "reset_dark");
        px(1, 4'hE, 8'hC0, "boot_d0");
        ghost(16, "ghost_16");
        px(20, 4'hD, 8'hC0, "old_frame_d1");
        tick(62, 1'b0, "ft_low");
        tick(63, 1'b1, "ft_wrap");
        ghost(64, "ghost_64");
        px(65, 4'hE, 8'hC0, "scan_d0");
        px(81, 4'hD, 8'hF9, "scan_d1");
        ghost(96, "ghost_96");
        px(97, 4'hB, 8'hA4, "scan_d2");
        px(113, 4'h7, 8'hB0, "scan_d3");
        px(127, 4'h7, 8'hB0, "scan_d3_end");
        px(152, 4'hD, 8'hF9, "tear_d1");
        px(170, 4'hB, 8'hA4, "tear_d2");
        px(185, 4'h7, 8'hB0, "tear_d3");
        tick(191, 1'b1, "ft_frame2");
        px(193, 4'hE, 8'h8E, "new_d0");
        px(210, 4'hD, 8'h8E, "new_d1");
        tick(255, 1'b1, "ft_coincide");
        px(257, 4'hE, 8'hF9, "coin_d0");
        px(275, 4'hD, 8'hA4, "coin_d1");
        px(290, 4'hB, 8'h99, "coin_d2");
        px(305, 4'h7, 8'h80, "coin_d3");
        px(337, 4'hD, 8'hA4, "pwm1_on");
        dark(338, "pwm1_off1");
        dark(339, "pwm1_off2");
        dark(340, "pwm1_off3");
        px(341, 4'hD, 8'hA4, "pwm1_on2");
        dark(353, "pwm0_a");
        dark(357, "pwm0_b");
        dark(360, "pwm0_c");
        px(370, 4'h7, 8'h80, "pwm3_a");
        px(371, 4'h7, 8'h80, "pwm3_b");
        px(372, 4'h7, 8'h80, "pwm3_c");
        ghost(384, "ghost_384");
        px(410, 4'hD, 8'hA4, "blank_pending");
        px(450, 4'hE, 8'hF9, "blink_on_d0");
        dark(466, "blank_d1");
        dark(470, "blank_d1b");
        dark(482, "blink_off_d2");
        px(498, 4'h7, 8'h00, "dp_d3");

        @(negedge CLK100MHZ);
        @(negedge CLK100MHZ);
        #1 BTNC = 1'b0;

        do_load(10, 16'h3210, 4'h0, 4'h0, 4'h0);
        do_load(150, 16'hFFFF, 4'h0, 4'h0, 4'h0);
        do_load(255, 16'h8421, 4'h0, 4'h0, 4'h0);
        wait_cyc(336);
        brightness = 2'd1;
        wait_cyc(352);
        brightness = 2'd0;
        wait_cyc(368);
        brightness = 2'd3;
        do_load(400, 16'h8421, 4'b1000, 4'b0010, 4'b0101);

        wait_cyc(520);
        @(posedge CLK100MHZ);
        #2 BTNC = 1'b1;
        #1;
        n_vec += 3;
        if (AN !== 4'hF) begin
            n_err++;
            $display("FAIL async_an: got AN=%b want 1111", AN);
        end
        if (SD !== 8'hFF) begin
            n_err++;
            $display("FAIL async_sd: got SD=%h want ff", SD);
        end
        if (frame_tick !== 1'b0) begin
            n_err++;
            $display("FAIL async_ft: got frame_tick=%b want 0", frame_tick);
        end
        add(0, 4'hF, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, "rst_async_dark");
        px(1, 4'hE, 8'hC0, "rst_first_d0");
        px(17, 4'hD, 8'hC0, "rst_blank_cleared");
        tick(30, 1'b0, "rst_ft_low");
        px(49, 4'h7, 8'hC0, "rst_dp_cleared");
        tick(62, 1'b0, "rst_ft_low2");
        tick(63, 1'b1, "rst_ft_first");
        for (int v = 0; v < 16; v++)
            px(64 * (v + 1) + 3, 4'hE, {1'b1, glyph_tbl[v]}, $sformatf("dec_%0h", v));
        @(negedge CLK100MHZ);
        @(negedge CLK100MHZ);
        #1 BTNC = 1'b0;

        for (int v = 0; v < 16; v++)
            do_load(64 * v + 5, 16'(v), 4'h0, 4'h0, 4'h0);
        wait_cyc(1040);

        while (q.size() != 0) begin
            left = q.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL %s never sampled (due t=%0d)", left.name, left.t);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        if (n_err != 0)
            $display("FAIL: %0d miscompares", n_err);
        else
            $display("PASS");
        $finish;
    end
endmodule
